// File: rtl/tdp36k_preload_seq_if.sv
// Command, stream and preload-bus signals of the TDP36K preload sequencer.
// master is the sequencer itself; slave is the loader / RAM side that faces it.
interface tdp36k_preload_seq_if #(
  parameter int RID_W = 20,
  parameter int AW    = 10,
  parameter int DW    = 36
);
  logic             START_i;
  logic             MODE_i;
  logic [RID_W-1:0] RAM_ID_i;
  logic [AW-1:0]    BASE_i;
  logic [AW:0]      LEN_i;
  // S_VALID_i/S_READY_o: a beat moves on a rising edge where both are high; S_VALID_i
  // never waits for S_READY_o, and a beat offered while S_READY_o is low stays pending.
  logic             S_VALID_i;
  logic [DW-1:0]    S_DATA_i;
  logic             S_READY_o;
  logic             BUSY_o;
  logic             DONE_o;
  logic [AW:0]      ERR_CNT_o;
  logic [AW-1:0]    FIRST_ERR_ADDR_o;
  logic             PL_INIT_o;
  logic             PL_ENA_o;
  logic             PL_REN_o;
  logic [1:0]       PL_WEN_o;
  logic [31:0]      PL_ADDR_o;
  logic [DW-1:0]    PL_DATA_o;
  logic [DW-1:0]    PL_DATA_i;
  logic [2:0]       dbg_state;

  modport master (
    input  START_i, MODE_i, RAM_ID_i, BASE_i, LEN_i, S_VALID_i, S_DATA_i, PL_DATA_i,
    output S_READY_o, BUSY_o, DONE_o, ERR_CNT_o, FIRST_ERR_ADDR_o,
    output PL_INIT_o, PL_ENA_o, PL_REN_o, PL_WEN_o, PL_ADDR_o, PL_DATA_o, dbg_state
  );

  modport slave (
    output START_i, MODE_i, RAM_ID_i, BASE_i, LEN_i, S_VALID_i, S_DATA_i, PL_DATA_i,
    input  S_READY_o, BUSY_o, DONE_o, ERR_CNT_o, FIRST_ERR_ADDR_o,
    input  PL_INIT_o, PL_ENA_o, PL_REN_o, PL_WEN_o, PL_ADDR_o, PL_DATA_o, dbg_state
  );
endinterface

// File: rtl/tdp36k_preload_seq.sv
// Fill / verify sequencer for the TDP36K preload bus: one command loads or checks one RAM
// instance word by word from a 36-bit stream, counting mismatches in verify mode.
module tdp36k_preload_seq #(
  parameter int RID_W       = 20,
  parameter int AW          = 10,
  parameter int DW          = 36,
  parameter int INIT_CYCLES = 4,
  parameter int READ_LAT    = 2
) (
  input  logic                  PL_CLK_i,
  input  logic                  RESET_ni,
  tdp36k_preload_seq_if.master  bus
);

  localparam int ICW = $clog2(INIT_CYCLES + 1);
  localparam int RCW = $clog2(READ_LAT + 1);
  localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_CYCLES - 1);
  localparam logic [RCW-1:0] WAIT_LAST = RCW'(READ_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_WR      = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_WAIT = 3'd4,
    S_CMP     = 3'd5,
    S_FIN     = 3'd6
  } state_t;

  state_t           state;
  logic             mode_q;
  logic [RID_W-1:0] rid_q;
  logic [AW-1:0]    cur;
  logic [AW:0]      remaining;
  logic [ICW-1:0]   init_cnt;
  logic [RCW-1:0]   wait_cnt;
  logic [DW-1:0]    rd_data;

  logic             s_ready;
  logic             busy;
  logic             done;
  logic [AW:0]      err_cnt;
  logic [AW-1:0]    first_err;
  logic             pl_init;
  logic             pl_ena;
  logic             pl_ren;
  logic [1:0]       pl_wen;
  logic [31:0]      pl_addr;
  logic [DW-1:0]    pl_data;

  always_ff @(posedge PL_CLK_i or negedge RESET_ni) begin
    if (!RESET_ni) begin
      state     <= S_IDLE;
      mode_q    <= 1'b0;
      rid_q     <= '0;
      cur       <= '0;
      remaining <= '0;
      init_cnt  <= '0;
      wait_cnt  <= '0;
      rd_data   <= '0;
      s_ready   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_cnt   <= '0;
      first_err <= '0;
      pl_init   <= 1'b0;
      pl_ena    <= 1'b0;
      pl_ren    <= 1'b0;
      pl_wen    <= 2'b00;
      pl_addr   <= '0;
      pl_data   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.START_i) begin
            mode_q    <= bus.MODE_i;
            rid_q     <= bus.RAM_ID_i;
            cur       <= bus.BASE_i;
            remaining <= bus.LEN_i;
            err_cnt   <= '0;
            first_err <= '0;
            init_cnt  <= '0;
            if (bus.LEN_i == '0) begin
              state <= S_FIN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state   <= S_INIT;
              busy    <= 1'b1;
              pl_init <= 1'b1;
            end
          end
        end

        // Outputs for the first cycle of the next state are set here, on the way out.
        S_INIT: begin
          if (init_cnt == INIT_LAST) begin
            pl_init <= 1'b0;
            if (mode_q) begin
              state   <= S_RD_REQ;
              pl_ena  <= 1'b1;
              pl_ren  <= 1'b1;
              pl_addr <= {rid_q, 2'b00, cur};
            end else begin
              state   <= S_WR;
              s_ready <= 1'b1;
            end
          end else begin
            init_cnt <= init_cnt + ICW'(1);
          end
        end

        // s_ready is high exactly while words remain, so a valid beat is an accepted beat.
        S_WR: begin
          if (remaining == '0) begin
            pl_ena <= 1'b0;
            pl_wen <= 2'b00;
            state  <= S_FIN;
            done   <= 1'b1;
            busy   <= 1'b0;
          end else if (bus.S_VALID_i && s_ready) begin
            pl_ena    <= 1'b1;
            pl_wen    <= 2'b11;
            pl_addr   <= {rid_q, 2'b00, cur};
            pl_data   <= bus.S_DATA_i;
            cur       <= cur + AW'(1);
            remaining <= remaining - (AW+1)'(1);
            if (remaining == (AW+1)'(1)) begin
              s_ready <= 1'b0;
            end
          end else begin
            pl_ena <= 1'b0;
            pl_wen <= 2'b00;
          end
        end

        S_RD_REQ: begin
          pl_ena   <= 1'b0;
          pl_ren   <= 1'b0;
          wait_cnt <= '0;
          state    <= S_RD_WAIT;
        end

        S_RD_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            rd_data <= bus.PL_DATA_i;
            s_ready <= 1'b1;
            state   <= S_CMP;
          end else begin
            wait_cnt <= wait_cnt + RCW'(1);
          end
        end

        S_CMP: begin
          if (bus.S_VALID_i && s_ready) begin
            s_ready <= 1'b0;
            if (rd_data != bus.S_DATA_i) begin
              err_cnt <= err_cnt + (AW+1)'(1);
              if (err_cnt == '0) begin
                first_err <= cur;
              end
            end
            cur       <= cur + AW'(1);
            remaining <= remaining - (AW+1)'(1);
            if (remaining == (AW+1)'(1)) begin
              state <= S_FIN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state   <= S_RD_REQ;
              pl_ena  <= 1'b1;
              pl_ren  <= 1'b1;
              pl_addr <= {rid_q, 2'b00, cur + AW'(1)};
            end
          end
        end

        S_FIN: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.S_READY_o        = s_ready;
  assign bus.BUSY_o           = busy;
  assign bus.DONE_o           = done;
  assign bus.ERR_CNT_o        = err_cnt;
  assign bus.FIRST_ERR_ADDR_o = first_err;
  assign bus.PL_INIT_o        = pl_init;
  assign bus.PL_ENA_o         = pl_ena;
  assign bus.PL_REN_o         = pl_ren;
  assign bus.PL_WEN_o         = pl_wen;
  assign bus.PL_ADDR_o        = pl_addr;
  assign bus.PL_DATA_o        = pl_data;
  assign bus.dbg_state        = state;

endmodule

// File: tb/tb_tdp36k_preload_seq.sv
// Self-checking bench for tdp36k_preload_seq: a behavioural RAM with read latency, a command
// driver that records bus activity, and one task per scenario comparing against the rules.
module tb_tdp36k_preload_seq;
  localparam int RID_W       = 20;
  localparam int AW          = 10;
  localparam int DW          = 36;
  localparam int INIT_CYCLES = 4;
  localparam int READ_LAT    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tdp36k_preload_seq_if #(.RID_W(RID_W), .AW(AW), .DW(DW)) bus ();

  tdp36k_preload_seq #(
    .RID_W(RID_W), .AW(AW), .DW(DW), .INIT_CYCLES(INIT_CYCLES), .READ_LAT(READ_LAT)
  ) dut (
    .PL_CLK_i(clk),
    .RESET_ni(rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // RAM model: writes land immediately, read data is presented only READ_LAT cycles after REN.
  logic [DW-1:0] mem [0:1023];
  logic          rp_v [0:READ_LAT];
  logic [AW-1:0] rp_a [0:READ_LAT];

  function automatic logic [DW-1:0] rand36();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= READ_LAT; i++) begin
        rp_v[i] = 1'b0;
        rp_a[i] = '0;
      end
    end else begin
      if (bus.PL_ENA_o && bus.PL_WEN_o == 2'b11) mem[bus.PL_ADDR_o[AW-1:0]] = bus.PL_DATA_o;
      for (int i = READ_LAT; i > 0; i--) begin
        rp_v[i] = rp_v[i-1];
        rp_a[i] = rp_a[i-1];
      end
      rp_v[0] = bus.PL_ENA_o && bus.PL_REN_o;
      rp_a[0] = bus.PL_ADDR_o[AW-1:0];
    end
    bus.PL_DATA_i = rp_v[READ_LAT] ? mem[rp_a[READ_LAT]] : rand36();
  end

  // Scoreboard inputs and observations of the last command.
  logic [DW-1:0] stim_q[$];
  logic [DW-1:0] exp_q[$];
  logic [31:0]   wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  int            wr_cyc_q[$];
  logic [31:0]   ren_addr_q[$];
  int            ren_cyc_q[$];
  int init_hi, init_first, done_cnt, done_cyc, bad_cnt, busy_low, beats;
  bit timed_out, zero_after_rst;

  function automatic logic [31:0] exp_addr(input logic [RID_W-1:0] rid, input logic [AW-1:0] base,
                                           input int i);
    logic [AW-1:0] w;
    w = base + AW'(i);
    return {rid, 2'b00, w};
  endfunction

  function automatic bit outs_zero();
    return (bus.S_READY_o === 1'b0) && (bus.BUSY_o === 1'b0) && (bus.DONE_o === 1'b0) &&
           (bus.ERR_CNT_o === '0) && (bus.FIRST_ERR_ADDR_o === '0) && (bus.PL_INIT_o === 1'b0) &&
           (bus.PL_ENA_o === 1'b0) && (bus.PL_REN_o === 1'b0) && (bus.PL_WEN_o === 2'b00) &&
           (bus.PL_ADDR_o === '0) && (bus.PL_DATA_o === '0);
  endfunction

  // vpat: 0 = valid always high, 1 = toggle 1,0,1.. over ready cycles, 2 = random.
  task automatic run_cmd(input logic mode, input logic [RID_W-1:0] rid, input logic [AW-1:0] base,
                         input logic [AW:0] len, input int vpat, input int busy_start_at,
                         input int abort_wr);
    int cyc, tog, max_cyc;
    bit v;
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    ren_addr_q.delete(); ren_cyc_q.delete();
    init_hi = 0; init_first = -1; done_cnt = 0; done_cyc = -1; bad_cnt = 0; busy_low = 0;
    beats = 0; timed_out = 0; zero_after_rst = 0;
    max_cyc = 200 + INIT_CYCLES + int'(len) * (READ_LAT + 10);
    cyc = 0; tog = 0;
    @(negedge clk);
    bus.START_i  = 1'b1;
    bus.MODE_i   = mode;
    bus.RAM_ID_i = rid;
    bus.BASE_i   = base;
    bus.LEN_i    = len;
    bus.S_VALID_i = (vpat == 0);
    bus.S_DATA_i  = (stim_q.size() > 0) ? stim_q[0] : '0;
    while (done_cnt == 0 && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      bus.START_i  = (cyc == busy_start_at);
      bus.MODE_i   = 1'($urandom_range(0, 1));
      bus.RAM_ID_i = RID_W'($urandom());
      bus.BASE_i   = AW'($urandom());
      bus.LEN_i    = (cyc == busy_start_at) ? '0 : (AW+1)'($urandom_range(1, 1024));
      if (bus.PL_INIT_o) begin
        if (init_hi == 0) init_first = cyc;
        init_hi++;
      end
      if (bus.PL_ENA_o && bus.PL_WEN_o == 2'b11) begin
        wr_addr_q.push_back(bus.PL_ADDR_o);
        wr_data_q.push_back(bus.PL_DATA_o);
        wr_cyc_q.push_back(cyc);
      end
      if (bus.PL_ENA_o && bus.PL_REN_o) begin
        ren_addr_q.push_back(bus.PL_ADDR_o);
        ren_cyc_q.push_back(cyc);
      end
      if ((bus.PL_WEN_o != 2'b00 && bus.PL_REN_o) || (bus.PL_WEN_o == 2'b01) ||
          (bus.PL_WEN_o == 2'b10) || (!bus.PL_ENA_o && (bus.PL_REN_o || bus.PL_WEN_o != 2'b00)) ||
          (bus.PL_ENA_o && !bus.PL_REN_o && bus.PL_WEN_o == 2'b00) ||
          (bus.PL_ENA_o && (bus.PL_INIT_o || bus.DONE_o || !bus.BUSY_o)) ||
          (bus.DONE_o && bus.BUSY_o))
        bad_cnt++;
      if (bus.DONE_o) begin
        done_cnt++;
        done_cyc = cyc;
      end else if (!bus.BUSY_o) begin
        busy_low++;
      end
      if (abort_wr > 0 && wr_addr_q.size() == abort_wr) begin
        rst_n = 1'b0;
        #1;
        zero_after_rst = outs_zero();
        repeat (5) begin
          @(negedge clk);
          if (bus.DONE_o) done_cnt++;
        end
        bus.S_VALID_i = 1'b0;
        bus.START_i = 1'b0;
        rst_n = 1'b1;
        return;
      end
      v = (vpat == 0) ? 1'b1 : (vpat == 1) ? (tog % 2 == 0) : ($urandom_range(0, 2) != 0);
      if (bus.S_READY_o) tog++;
      bus.S_VALID_i = v;
      bus.S_DATA_i  = (beats < stim_q.size()) ? stim_q[beats] : rand36();
      if (v && bus.S_READY_o) beats++;
    end
    if (done_cnt == 0) timed_out = 1;
    repeat (3) begin
      @(negedge clk);
      if (bus.DONE_o) done_cnt++;
      if (bus.PL_ENA_o || bus.PL_INIT_o || bus.BUSY_o) bad_cnt++;
    end
    bus.S_VALID_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (!outs_zero()) begin
      errors++; $display("FAIL reset_hold: outputs not all zero during reset (busy=%b ena=%b)",
                         bus.BUSY_o, bus.PL_ENA_o);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (!outs_zero()) begin
      errors++; $display("FAIL reset_release: outputs not zero after release, busy=%b", bus.BUSY_o);
    end
  endtask

  task automatic test_fill_back_to_back();
    stim_q.delete();
    for (int i = 0; i < 4; i++) stim_q.push_back(DW'(i + 1));
    run_cmd(1'b0, 20'h00005, 10'd0, 11'd4, 0, -1, 0);
    checks++;
    if (timed_out || done_cnt != 1) begin
      errors++; $display("FAIL b2b_done: got %0d done pulses, required 1 (timeout=%0d)",
                         done_cnt, timed_out);
    end
    checks++;
    if (init_hi != INIT_CYCLES || init_first != 1) begin
      errors++; $display("FAIL b2b_init: got %0d cycles from cycle %0d, required %0d from 1",
                         init_hi, init_first, INIT_CYCLES);
    end
    checks++;
    if (wr_addr_q.size() != 4) begin
      errors++; $display("FAIL b2b_wr_count: got %0d writes, required 4", wr_addr_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_addr_q[i] !== 32'h00005000 + 32'(i) || wr_data_q[i] !== stim_q[i] ||
            wr_cyc_q[i] != INIT_CYCLES + 2 + i) begin
          errors++; $display("FAIL b2b_wr%0d: got addr %h data %h cyc %0d, required %h %h %0d", i,
                             wr_addr_q[i], wr_data_q[i], wr_cyc_q[i], 32'h00005000 + 32'(i),
                             stim_q[i], INIT_CYCLES + 2 + i);
        end
      end
      checks++;
      if (done_cyc != wr_cyc_q[3] + 1) begin
        errors++; $display("FAIL b2b_done_cyc: got %0d, required %0d", done_cyc, wr_cyc_q[3] + 1);
      end
    end
    checks++;
    if (beats != 4 || bad_cnt != 0 || busy_low != 0) begin
      errors++; $display("FAIL b2b_protocol: beats %0d bad %0d busy_low %0d, required 4 0 0",
                         beats, bad_cnt, busy_low);
    end
  endtask

  task automatic test_fill_stall_wrap();
    logic [RID_W-1:0] rid;
    rid = RID_W'($urandom());
    stim_q.delete();
    for (int i = 0; i < 3; i++) stim_q.push_back(rand36());
    run_cmd(1'b0, rid, 10'd1022, 11'd3, 1, -1, 0);
    checks++;
    if (wr_addr_q.size() != 3 || done_cnt != 1) begin
      errors++; $display("FAIL stall_count: got %0d writes %0d done, required 3 1",
                         wr_addr_q.size(), done_cnt);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wr_addr_q[i] !== exp_addr(rid, 10'd1022, i) || wr_data_q[i] !== stim_q[i]) begin
          errors++; $display("FAIL stall_wr%0d: got %h/%h, required %h/%h", i, wr_addr_q[i],
                             wr_data_q[i], exp_addr(rid, 10'd1022, i), stim_q[i]);
        end
      end
      checks++;
      if (wr_cyc_q[1] - wr_cyc_q[0] != 2 || wr_cyc_q[2] - wr_cyc_q[1] != 2) begin
        errors++; $display("FAIL stall_gaps: got write cycles %0d %0d %0d, required spacing 2",
                           wr_cyc_q[0], wr_cyc_q[1], wr_cyc_q[2]);
      end
    end
    checks++;
    if (bad_cnt != 0 || beats != 3) begin
      errors++; $display("FAIL stall_protocol: bad %0d beats %0d, required 0 3", bad_cnt, beats);
    end
  endtask

  task automatic check_verify(input string name, input logic [RID_W-1:0] rid,
                              input logic [AW-1:0] base, input int len, input int exp_err,
                              input logic [AW-1:0] exp_first);
    int min_gap;
    checks++;
    if (timed_out || done_cnt != 1 || wr_addr_q.size() != 0 || bad_cnt != 0 || beats != len) begin
      errors++; $display("FAIL %s_protocol: done %0d writes %0d bad %0d beats %0d, required 1 0 0 %0d",
                         name, done_cnt, wr_addr_q.size(), bad_cnt, beats, len);
    end
    checks++;
    if (bus.ERR_CNT_o !== (AW+1)'(exp_err)) begin
      errors++; $display("FAIL %s_err_cnt: got %0d, required %0d", name, bus.ERR_CNT_o, exp_err);
    end
    if (exp_err != 0) begin
      checks++;
      if (bus.FIRST_ERR_ADDR_o !== exp_first) begin
        errors++; $display("FAIL %s_first_err: got %0d, required %0d", name,
                           bus.FIRST_ERR_ADDR_o, exp_first);
      end
    end
    checks++;
    if (ren_addr_q.size() != len) begin
      errors++; $display("FAIL %s_ren_count: got %0d, required %0d", name, ren_addr_q.size(), len);
    end else begin
      min_gap = 1 << 20;
      for (int i = 0; i < len; i++) begin
        if (ren_addr_q[i] !== exp_addr(rid, base, i)) begin
          checks++; errors++;
          $display("FAIL %s_ren_addr%0d: got %h, required %h", name, i, ren_addr_q[i],
                   exp_addr(rid, base, i));
        end
        if (i > 0 && ren_cyc_q[i] - ren_cyc_q[i-1] < min_gap) min_gap = ren_cyc_q[i] - ren_cyc_q[i-1];
      end
      if (len > 1) begin
        checks++;
        if (min_gap < READ_LAT + 2) begin
          errors++; $display("FAIL %s_ren_gap: got %0d, required >= %0d", name, min_gap, READ_LAT + 2);
        end
      end
    end
  endtask

  task automatic run_fill_verify(input string name, input int len, input int n_bad);
    logic [RID_W-1:0] rid;
    logic [AW-1:0] base, exp_first;
    logic [DW-1:0] flip;
    int exp_err, k;
    bit corrupt;
    rid  = RID_W'($urandom());
    base = AW'($urandom_range(0, 1023));
    stim_q.delete();
    for (int i = 0; i < len; i++) stim_q.push_back(rand36());
    exp_q = stim_q;
    run_fill_once(rid, base, len);
    stim_q.delete();
    exp_err = 0; exp_first = '0;
    k = $urandom_range(0, len - 1);
    for (int i = 0; i < len; i++) begin
      corrupt = (n_bad == 1) ? (i == 1) : (n_bad > 1) && (i == k || $urandom_range(0, 3) == 0);
      flip = rand36();
      if (flip == '0) flip = 1;
      stim_q.push_back(corrupt ? (exp_q[i] ^ flip) : exp_q[i]);
      if (corrupt) begin
        if (exp_err == 0) exp_first = base + AW'(i);
        exp_err++;
      end
    end
    run_cmd(1'b1, rid, base, (AW+1)'(len), 2, -1, 0);
    check_verify(name, rid, base, len, exp_err, exp_first);
  endtask

  task automatic run_fill_once(input logic [RID_W-1:0] rid, input logic [AW-1:0] base, input int len);
    run_cmd(1'b0, rid, base, (AW+1)'(len), 2, -1, 0);
    checks++;
    if (timed_out || wr_addr_q.size() != len) begin
      errors++; $display("FAIL fill_setup: got %0d writes, required %0d", wr_addr_q.size(), len);
    end
  endtask

  task automatic test_verify();
    run_fill_verify("verify_one", 8, 1);
    run_fill_verify("verify_rand", 8, 2);
  endtask

  task automatic test_reset_mid_fill();
    logic [RID_W-1:0] rid;
    rid = RID_W'($urandom());
    stim_q.delete();
    for (int i = 0; i < 8; i++) stim_q.push_back(rand36());
    run_cmd(1'b0, rid, 10'd100, 11'd8, 0, -1, 2);
    checks++;
    if (!zero_after_rst || done_cnt != 0 || wr_addr_q.size() != 2) begin
      errors++; $display("FAIL reset_mid: zero %0d done %0d writes %0d, required 1 0 2",
                         zero_after_rst, done_cnt, wr_addr_q.size());
    end
    stim_q.delete();
    for (int i = 0; i < 3; i++) stim_q.push_back(rand36());
    run_cmd(1'b0, rid, 10'd200, 11'd3, 0, -1, 0);
    checks++;
    if (done_cnt != 1 || wr_addr_q.size() != 3 || bus.ERR_CNT_o !== '0 || bad_cnt != 0) begin
      errors++; $display("FAIL reset_rerun: done %0d writes %0d err %0d bad %0d, required 1 3 0 0",
                         done_cnt, wr_addr_q.size(), bus.ERR_CNT_o, bad_cnt);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wr_addr_q[i] !== exp_addr(rid, 10'd200, i) || wr_data_q[i] !== stim_q[i]) begin
          errors++; $display("FAIL reset_rerun_wr%0d: got %h/%h, required %h/%h", i, wr_addr_q[i],
                             wr_data_q[i], exp_addr(rid, 10'd200, i), stim_q[i]);
        end
      end
    end
  endtask

  task automatic test_full_wrap();
    run_fill_verify("verify_full", 1024, 2);
  endtask

  task automatic test_len0_and_busy_start();
    logic [RID_W-1:0] rid;
    rid = RID_W'($urandom());
    stim_q.delete();
    run_cmd(1'b0, rid, 10'd7, 11'd0, 0, -1, 0);
    checks++;
    if (done_cnt != 1 || done_cyc != 1 || wr_addr_q.size() != 0 || ren_addr_q.size() != 0 ||
        init_hi != 0 || bad_cnt != 0) begin
      errors++; $display("FAIL len0: done %0d at %0d wr %0d ren %0d init %0d, required 1 at 1, 0 0 0",
                         done_cnt, done_cyc, wr_addr_q.size(), ren_addr_q.size(), init_hi);
    end
    checks++;
    if (bus.ERR_CNT_o !== '0) begin
      errors++; $display("FAIL len0_err_clear: got %0d, required 0", bus.ERR_CNT_o);
    end
    for (int s = 0; s < 2; s++) begin
      stim_q.delete();
      for (int i = 0; i < 6; i++) stim_q.push_back(rand36());
      run_cmd(1'b0, rid, 10'd1020, 11'd6, 0, (s == 0) ? 2 : INIT_CYCLES + 4, 0);
      checks++;
      if (done_cnt != 1 || wr_addr_q.size() != 6 || beats != 6 || bad_cnt != 0) begin
        errors++; $display("FAIL busy_start%0d: done %0d writes %0d beats %0d bad %0d, required 1 6 6 0",
                           s, done_cnt, wr_addr_q.size(), beats, bad_cnt);
      end else begin
        for (int i = 0; i < 6; i++) begin
          checks++;
          if (wr_addr_q[i] !== exp_addr(rid, 10'd1020, i) || wr_data_q[i] !== stim_q[i]) begin
            errors++; $display("FAIL busy_start%0d_wr%0d: got %h/%h, required %h/%h", s, i,
                               wr_addr_q[i], wr_data_q[i], exp_addr(rid, 10'd1020, i), stim_q[i]);
          end
        end
      end
    end
  endtask

  initial begin
    bus.START_i   = 1'b0;
    bus.MODE_i    = 1'b0;
    bus.RAM_ID_i  = '0;
    bus.BASE_i    = '0;
    bus.LEN_i     = '0;
    bus.S_VALID_i = 1'b0;
    bus.S_DATA_i  = '0;
    test_reset();
    test_fill_back_to_back();
    test_fill_stall_wrap();
    test_verify();
    test_reset_mid_fill();
    test_full_wrap();
    test_len0_and_busy_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
